// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer. in_ready comes straight from the skid valid flop, so downstream
// backpressure never propagates combinationally upstream. Also keeps
// saturating stall/flush statistics.
module pipe_stage_skid #(
    parameter int                 DATA_W     = 96,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
    parameter int                 CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    // Encoding is {main_v, skid_v}; ORPHAN (0,1) should never be reached.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        ORPHAN = 2'b01,
        FULL   = 2'b10,
        SKID   = 2'b11
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_d, main_d_nxt;
    logic [DATA_W-1:0] skid_d, skid_d_nxt;
    logic              in_fire, out_fire;

    assign out_valid = state[1];
    assign in_ready  = !state[0];
    assign out_data  = main_d;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // State and payload registers; reset beats everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_d <= BUBBLE_VAL;
            skid_d <= BUBBLE_VAL;
        end else begin
            state  <= state_nxt;
            main_d <= main_d_nxt;
            skid_d <= skid_d_nxt;
        end
    end

    // Next-state and payload movement; flush overrides normal transitions.
    always_comb begin
        state_nxt  = state;
        main_d_nxt = main_d;
        skid_d_nxt = skid_d;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt  = FULL;
                    main_d_nxt = in_data;
                end
            end
            FULL: begin
                if (in_fire && out_fire) begin
                    main_d_nxt = in_data;
                end else if (in_fire) begin
                    state_nxt  = SKID;
                    skid_d_nxt = in_data;
                end else if (out_fire) begin
                    state_nxt  = EMPTY;
                    main_d_nxt = BUBBLE_VAL;
                end
            end
            SKID: begin
                if (out_fire) begin
                    state_nxt  = FULL;
                    main_d_nxt = skid_d;
                    skid_d_nxt = BUBBLE_VAL;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        // An in_fire during flush is dropped; an out_fire has already
        // handed its entry to downstream.
        if (flush) begin
            state_nxt  = EMPTY;
            main_d_nxt = BUBBLE_VAL;
            skid_d_nxt = BUBBLE_VAL;
        end
    end

    // Saturating statistics; stalls are counted even in a flush cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: a vector table for reset/streaming/skid/flush cases,
// then hand sequences for counter saturation and a non-zero bubble value.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid;
    logic [7:0]  out_data;
    logic [15:0] stall_cycles, flush_count;

    logic        in_ready4, out_valid4;
    logic [7:0]  out_data4;
    logic [3:0]  stall_cycles4, flush_count4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(8), .BUBBLE_VAL(8'h00), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Narrow-counter copy with a distinctive bubble, fed the same stimulus.
    pipe_stage_skid #(.DATA_W(8), .BUBBLE_VAL(8'hEE), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .stall_cycles(stall_cycles4), .flush_count(flush_count4)
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [7:0]  d;
        logic        ordy;
        logic        eov;
        logic [7:0]  eod;
        logic        eir;
        logic [15:0] est;
        logic [15:0] efl;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic iv, input logic [7:0] d, input logic ordy);
        reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst fl iv d      ordy  eov eod    eir est     efl
        vecs[0]  = '{1'b1,1'b0,1'b1,8'hAA,1'b0, 1'b0,8'h00,1'b1,16'd0,16'd0}; // reset
        vecs[1]  = '{1'b1,1'b0,1'b1,8'hAA,1'b0, 1'b0,8'h00,1'b1,16'd0,16'd0};
        vecs[2]  = '{1'b0,1'b0,1'b1,8'h10,1'b1, 1'b1,8'h10,1'b1,16'd0,16'd0}; // stream
        vecs[3]  = '{1'b0,1'b0,1'b1,8'h11,1'b1, 1'b1,8'h11,1'b1,16'd0,16'd0};
        vecs[4]  = '{1'b0,1'b0,1'b1,8'h12,1'b1, 1'b1,8'h12,1'b1,16'd0,16'd0};
        vecs[5]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,8'h00,1'b1,16'd0,16'd0};
        vecs[6]  = '{1'b0,1'b0,1'b1,8'h20,1'b1, 1'b1,8'h20,1'b1,16'd0,16'd0}; // skid
        vecs[7]  = '{1'b0,1'b0,1'b1,8'h21,1'b0, 1'b1,8'h20,1'b0,16'd1,16'd0};
        vecs[8]  = '{1'b0,1'b0,1'b1,8'h22,1'b0, 1'b1,8'h20,1'b0,16'd2,16'd0};
        vecs[9]  = '{1'b0,1'b0,1'b1,8'h22,1'b0, 1'b1,8'h20,1'b0,16'd3,16'd0};
        vecs[10] = '{1'b0,1'b0,1'b1,8'h22,1'b1, 1'b1,8'h21,1'b1,16'd3,16'd0};
        vecs[11] = '{1'b0,1'b0,1'b1,8'h22,1'b1, 1'b1,8'h22,1'b1,16'd3,16'd0};
        vecs[12] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,8'h00,1'b1,16'd3,16'd0};
        vecs[13] = '{1'b0,1'b0,1'b1,8'h23,1'b0, 1'b1,8'h23,1'b1,16'd3,16'd0}; // flush in SKID
        vecs[14] = '{1'b0,1'b0,1'b1,8'h24,1'b0, 1'b1,8'h23,1'b0,16'd4,16'd0};
        vecs[15] = '{1'b0,1'b1,1'b1,8'h30,1'b0, 1'b0,8'h00,1'b1,16'd5,16'd1};
        vecs[16] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,8'h00,1'b1,16'd5,16'd1};
        vecs[17] = '{1'b0,1'b0,1'b1,8'h40,1'b0, 1'b1,8'h40,1'b1,16'd5,16'd1}; // flush + out_fire
        vecs[18] = '{1'b0,1'b1,1'b0,8'h00,1'b1, 1'b0,8'h00,1'b1,16'd5,16'd2};
        vecs[19] = '{1'b0,1'b0,1'b1,8'h50,1'b0, 1'b1,8'h50,1'b1,16'd5,16'd2}; // reset mid-stall
        vecs[20] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b1,8'h50,1'b1,16'd6,16'd2};
        vecs[21] = '{1'b1,1'b1,1'b1,8'h60,1'b0, 1'b0,8'h00,1'b1,16'd0,16'd0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        for (int i = 0; i < 22; i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
            check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].eod));
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].eir));
            check($sformatf("v%0d stall_cycles", i), 32'(stall_cycles), 32'(vecs[i].est));
            check($sformatf("v%0d flush_count", i), 32'(flush_count), 32'(vecs[i].efl));
        end

        // Narrow copy just came out of reset: bubble value on its output.
        check("bubble4 reset out_data", 32'(out_data4), 32'h0000_00EE);
        check("bubble4 reset out_valid", 32'(out_valid4), 32'h0);

        // Saturation: load one entry, then stall 20 cycles.
        step(1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        check("sat load out_data4", 32'(out_data4), 32'h0000_0055);
        for (int c = 1; c <= 20; c++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            if (c == 14) check("sat4 at 14", 32'(stall_cycles4), 32'd14);
            if (c == 15) check("sat4 at 15", 32'(stall_cycles4), 32'd15);
        end
        check("sat4 after 20", 32'(stall_cycles4), 32'd15);
        check("sat16 after 20", 32'(stall_cycles), 32'd20);

        // Flush with the stall still pending: stall counted, bubble reloaded.
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("flush4 out_data", 32'(out_data4), 32'h0000_00EE);
        check("flush4 out_valid", 32'(out_valid4), 32'h0);
        check("flush4 flush_count", 32'(flush_count4), 32'd1);
        check("flush16 stall_cycles", 32'(stall_cycles), 32'd21);
        check("flush4 stall held", 32'(stall_cycles4), 32'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush, and stall/flush statistics counters. It replaces the fixed-width inter-stage registers (IF/ID, ID/EX, and so on) in the pipelined RISC-V core. A single module instantiated with different `DATA_W` carries any stage payload, such as {PC, instruction}. The skid buffer means `in_ready` is driven only from registers, which breaks the combinational stall path that otherwise runs back through each stage.

## Interface

Parameters:
- `DATA_W`, default 96: payload width, e.g. 64-bit PC + 32-bit instruction.
- `BUBBLE_VAL`, default 0: value driven on `out_data` whenever the stage holds no valid entry.
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high; highest priority.
- `flush`  in  1: synchronous, active-high; discards all held and incoming entries.
- `in_valid`  in  1: upstream entry present.
- `in_ready`  out  1: stage can accept; a function of registered state only.
- `in_data`  in  `DATA_W`: upstream payload.
- `out_valid`  out  1: registered; entry available downstream.
- `out_ready`  in  1: downstream accepts.
- `out_data`  out  `DATA_W`: registered payload.
- `stall_cycles`  out  `CNT_W`: saturating count of cycles with `out_valid=1` and `out_ready=0`.
- `flush_count`  out  `CNT_W`: saturating count of flush cycles.

## Operation

Storage:
- Main register: `main_v`, `main_d`.
- Skid register: `skid_v`, `skid_d`.
- Outputs: `out_valid = main_v`, `out_data = main_d`, `in_ready = !skid_v`.

Handshake events:
- `in_fire = in_valid & in_ready`.
- `out_fire = out_valid & out_ready`.

State machine, encoded as {`main_v`, `skid_v`}:
- **EMPTY (0,0)**
  - `in_fire` → FULL, `main_d <= in_data`.
  - Otherwise stay.
- **FULL (1,0)**
  - `in_fire & out_fire` → FULL, `main_d <= in_data`.
  - `in_fire & !out_fire` → SKID, `skid_d <= in_data`.
  - `!in_fire & out_fire` → EMPTY, `main_d <= BUBBLE_VAL`.
  - Otherwise hold.
- **SKID (1,1)**
  - `in_ready = 0`.
  - `out_fire` → FULL, `main_d <= skid_d`, `skid_d <= BUBBLE_VAL`.
  - Otherwise hold.
- (0,1) is unreachable. If ever entered, the next edge goes to EMPTY.

Priority per edge:
1. `reset`
2. `flush`
3. Normal transitions.

Flush:
- Next state is EMPTY, and both data registers are loaded with `BUBBLE_VAL`.
- A concurrent `in_fire` entry is discarded. Upstream is flushed in the same cycle by the hazard unit, so the apparent acceptance is harmless.
- A concurrent `out_fire` counts as delivered; downstream owns that entry.

Counters:
- Each counter increments by 1 per qualifying cycle and holds at all-ones.
- `stall_cycles` counts in every cycle, including a flush cycle.
- `flush_count` counts cycles with `flush=1` and `reset=0`.

Ordering and loss: FIFO order is preserved, and no entry is ever lost or duplicated outside flush.

## Timing

- Reset values:
  - `out_valid=0`, `in_ready=1`.
  - `out_data=BUBBLE_VAL`, `skid_d=BUBBLE_VAL`.
  - `stall_cycles=0`, `flush_count=0`.
- Latency: an entry accepted on edge N is visible on `out_data`/`out_valid` after edge N (one cycle).
- Throughput: one entry per cycle while `out_ready=1`.
- Backpressure:
  - After `out_ready` drops, at most one more entry is accepted (into skid).
  - `in_ready` falls the cycle after the skid fills.
  - `in_ready` rises the cycle after the skid drains.
- Combinational paths:
  - No path from `out_ready` to `in_ready`.
  - No path from any input to `out_valid`/`out_data`.
- Reset or flush asserted mid-stall: the stage is EMPTY after that edge; counter behaviour is as specified above.

## Test plan

- **Reset**: hold `reset` for 2 cycles with `in_valid=1`, `in_data=0xAA`. Required: `out_valid=0`, `out_data=0`, `in_ready=1`, both counters 0.
- **Streaming**: `out_ready=1`, present 0x10, 0x11, 0x12 on consecutive cycles. Required: each appears on `out_data` one cycle later with `out_valid=1`, `stall_cycles=0`.
- **Backpressure/skid**:
  - Stimulus: stream 0x20, 0x21, 0x22 with `out_ready=0` from the second cycle, hold 3 cycles, then `out_ready=1`.
  - Required: 0x20 held, 0x21 in skid, `in_ready=0`, 0x22 not accepted until `in_ready` returns to 1, output order 0x20, 0x21, 0x22, `stall_cycles=3`.
- **Flush in SKID state**:
  - Stimulus: assert `flush` for 1 cycle with `in_valid=1`, `in_data=0x30`.
  - Required: next cycle `out_valid=0`, `out_data=BUBBLE_VAL`, `in_ready=1`, 0x30 never appears, `flush_count=1`.
- **Flush with concurrent out_fire**:
  - Stimulus: in FULL state with 0x40, assert `out_ready=1` and `flush=1` together.
  - Required: 0x40 counted delivered, stage EMPTY next cycle.
- **Saturation**: `CNT_W=4`, hold a stall for 20 cycles. Required: `stall_cycles` stops at 15.
